// File: rtl/eth_rx_dispatch_if.sv
// Downstream handshakes of eth_rx_dispatch: payload byte stream to the command
// decoder and the ARP request/ack pair to the ARP responder.
interface eth_rx_dispatch_if;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic        cmd_last;
    logic        cmd_ready;
    logic        arp_req;
    logic [47:0] arp_mac;
    logic        arp_ack;

    modport master (output cmd_data, cmd_valid, cmd_last, arp_req, arp_mac,
                    input  cmd_ready, arp_ack);
    modport slave  (input  cmd_data, cmd_valid, cmd_last, arp_req, arp_mac,
                    output cmd_ready, arp_ack);
endinterface

// File: rtl/eth_rx_dispatch.sv
// Filters parser UDP payloads into a one-frame buffer, commits on frame_done, drains to the
// command decoder and flags ARP frames. Define RX_DISPATCH_STATS_EN to build the counters.
module eth_rx_dispatch #(
    parameter int unsigned BUF_AW = 6,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic [31:0]       cfg_local_ip,
    input  logic [15:0]       cfg_udp_port,
    input  logic              is_arp,
    input  logic [47:0]       src_mac,
    input  logic [31:0]       src_ip,
    input  logic [31:0]       dst_ip,
    input  logic [15:0]       udp_src_port,
    input  logic [15:0]       udp_dst_port,
    input  logic [7:0]        udp_payload,
    input  logic              udp_payload_valid,
    input  logic              udp_payload_last,
    input  logic              frame_done,
    eth_rx_dispatch_if.master dn,
    output logic [47:0]       reply_mac,
    output logic [31:0]       reply_ip,
    output logic [15:0]       reply_port,
    output logic [STAT_W-1:0] stat_rx_ok,
    output logic [STAT_W-1:0] stat_rx_drop
);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WAIT_DONE, S_DROP, S_DRAIN} state_e;

    localparam logic [BUF_AW-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    logic [BUF_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0] rd_ptr_q, last_addr_q;
    logic [7:0]        buf_mem [2**BUF_AW];
    logic [47:0]       shd_mac_q, reply_mac_q, arp_mac_q;
    logic [31:0]       shd_ip_q, reply_ip_q;
    logic [15:0]       shd_port_q, reply_port_q;
    logic [7:0]        cmd_data_q;
    logic              cmd_valid_q, cmd_last_q;
    logic              stray_q, stray_d;
    logic              arp_req_q;
    logic              filter_ok, mem_we, shadow_we, commit, fetch, accept, ok_inc, drop_inc;

    assign filter_ok = (dst_ip == cfg_local_ip) && (udp_dst_port == cfg_udp_port);
    assign accept    = cmd_valid_q && dn.cmd_ready;
    // Refill the output register whenever it is empty or being taken, until the last byte is loaded.
    assign fetch     = (state_q == S_DRAIN) && (!cmd_valid_q || dn.cmd_ready) &&
                       !(cmd_valid_q && cmd_last_q);
    assign ok_inc    = (state_q == S_DRAIN) && accept && cmd_last_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        mem_we    = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        drop_inc  = 1'b0;
        stray_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (udp_payload_valid) begin
                    if (filter_ok) begin
                        mem_we    = 1'b1;
                        shadow_we = 1'b1;
                        wr_ptr_d  = '0;
                        state_d   = udp_payload_last ? S_WAIT_DONE : S_RECV;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_RECV: begin
                if (udp_payload_valid && wr_ptr_q == ADDR_MAX) begin
                    drop_inc = frame_done;
                    state_d  = frame_done ? S_IDLE : S_DROP;
                end else begin
                    if (udp_payload_valid) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (udp_payload_valid && udp_payload_last) begin
                        state_d = S_WAIT_DONE;
                    end else if (frame_done) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    commit  = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DROP: begin
                if (frame_done) begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DRAIN: begin
                // A frame overlapping the drain is ignored and counted once at its frame_done.
                stray_d  = (stray_q || udp_payload_valid) && !frame_done;
                drop_inc = frame_done && (stray_q || udp_payload_valid);
                if (ok_inc) state_d = stray_d ? S_DROP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk50) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the buffer is not reset; resetting the pointers is enough to abandon its contents.
    always_ff @(posedge clk50) begin
        if (mem_we) buf_mem[wr_ptr_d] <= udp_payload;
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_addr_q  <= '0;
            stray_q      <= 1'b0;
            shd_mac_q    <= '0;
            shd_ip_q     <= '0;
            shd_port_q   <= '0;
            reply_mac_q  <= '0;
            reply_ip_q   <= '0;
            reply_port_q <= '0;
            cmd_data_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_last_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            stray_q  <= (state_d == S_DRAIN) && stray_d;
            if (shadow_we) begin
                shd_mac_q  <= src_mac;
                shd_ip_q   <= src_ip;
                shd_port_q <= udp_src_port;
            end
            if (commit) begin
                reply_mac_q  <= shd_mac_q;
                reply_ip_q   <= shd_ip_q;
                reply_port_q <= shd_port_q;
                last_addr_q  <= wr_ptr_q;
                rd_ptr_q     <= '0;
            end
            if (fetch) begin
                cmd_data_q  <= buf_mem[rd_ptr_q];
                cmd_valid_q <= 1'b1;
                cmd_last_q  <= (rd_ptr_q == last_addr_q);
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end else if (accept) begin
                cmd_valid_q <= 1'b0;
                cmd_last_q  <= 1'b0;
            end
        end
    end

    // ARP request is independent of the UDP path; a pending request blocks newer ARP frames.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            arp_req_q <= 1'b0;
            arp_mac_q <= '0;
        end else if (arp_req_q) begin
            if (dn.arp_ack) arp_req_q <= 1'b0;
        end else if (frame_done && is_arp) begin
            arp_req_q <= 1'b1;
            arp_mac_q <= src_mac;
        end
    end

`ifdef RX_DISPATCH_STATS_EN
    logic [STAT_W-1:0] ok_cnt_q, drop_cnt_q;

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (ok_inc && ok_cnt_q != '1)     ok_cnt_q   <= ok_cnt_q + 1'b1;
            if (drop_inc && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign stat_rx_ok   = ok_cnt_q;
    assign stat_rx_drop = drop_cnt_q;
`else
    logic unused_stat_strobes;
    assign unused_stat_strobes = ok_inc | drop_inc;
    assign stat_rx_ok          = '0;
    assign stat_rx_drop        = '0;
`endif

    assign dn.cmd_data  = cmd_data_q;
    assign dn.cmd_valid = cmd_valid_q;
    assign dn.cmd_last  = cmd_last_q;
    assign dn.arp_req   = arp_req_q;
    assign dn.arp_mac   = arp_mac_q;
    assign reply_mac    = reply_mac_q;
    assign reply_ip     = reply_ip_q;
    assign reply_port   = reply_port_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Directed self-checking bench for eth_rx_dispatch; counter expectations follow
// whether RX_DISPATCH_STATS_EN is defined for the build.
module tb_eth_rx_dispatch;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0164;
    localparam logic [15:0] LOCAL_PORT = 16'h1388;
`ifdef RX_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk50 = 1'b0;
    logic        rst_n;
    logic        is_arp, udp_payload_valid, udp_payload_last, frame_done;
    logic [47:0] src_mac, reply_mac;
    logic [31:0] src_ip, dst_ip, reply_ip;
    logic [15:0] udp_src_port, udp_dst_port, reply_port;
    logic [7:0]  udp_payload;
    logic [15:0] stat_rx_ok, stat_rx_drop;

    int vectors     = 0;
    int miscompares = 0;

    eth_rx_dispatch_if dn_if ();

    eth_rx_dispatch dut (
        .clk50             (clk50),
        .rst_n             (rst_n),
        .cfg_local_ip      (LOCAL_IP),
        .cfg_udp_port      (LOCAL_PORT),
        .is_arp            (is_arp),
        .src_mac           (src_mac),
        .src_ip            (src_ip),
        .dst_ip            (dst_ip),
        .udp_src_port      (udp_src_port),
        .udp_dst_port      (udp_dst_port),
        .udp_payload       (udp_payload),
        .udp_payload_valid (udp_payload_valid),
        .udp_payload_last  (udp_payload_last),
        .frame_done        (frame_done),
        .dn                (dn_if),
        .reply_mac         (reply_mac),
        .reply_ip          (reply_ip),
        .reply_port        (reply_port),
        .stat_rx_ok        (stat_rx_ok),
        .stat_rx_drop      (stat_rx_drop)
    );

    always #10 clk50 = ~clk50;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_stat(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    task automatic tick();
        @(negedge clk50);
    endtask

    task automatic set_hdr(input logic [47:0] mac, input logic [31:0] sip,
                           input logic [15:0] sport, input logic [15:0] dport,
                           input logic [31:0] dip);
        src_mac      = mac;
        src_ip       = sip;
        udp_src_port = sport;
        udp_dst_port = dport;
        dst_ip       = dip;
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < n; i++) begin
            udp_payload       = 8'(base + step * i);
            udp_payload_valid = 1'b1;
            udp_payload_last  = (i == n - 1);
            tick();
        end
        udp_payload_valid = 1'b0;
        udp_payload_last  = 1'b0;
        frame_done        = 1'b1;
        tick();
        frame_done        = 1'b0;
    endtask

    task automatic arp_frame(input logic [47:0] mac, input logic ack);
        is_arp        = 1'b1;
        src_mac       = mac;
        frame_done    = 1'b1;
        dn_if.arp_ack = ack;
        tick();
        is_arp        = 1'b0;
        frame_done    = 1'b0;
        dn_if.arp_ack = 1'b0;
    endtask

    // Collects n bytes, checking order, cmd_last and stability while stalled.
    task automatic receive(input int n, input logic [7:0] base, input logic [7:0] step,
                           input bit toggle, input string tag);
        int       got = 0;
        int       cyc = 0;
        bit       stalled = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_last = 1'b0;
        while (got < n && cyc < 400) begin
            if (stalled)
                check({tag, " hold"}, {dn_if.cmd_valid, dn_if.cmd_data, dn_if.cmd_last},
                      {1'b1, prev_data, prev_last});
            dn_if.cmd_ready = toggle ? cyc[0] : 1'b1;
            stalled   = dn_if.cmd_valid && !dn_if.cmd_ready;
            prev_data = dn_if.cmd_data;
            prev_last = dn_if.cmd_last;
            if (dn_if.cmd_valid && dn_if.cmd_ready) begin
                check({tag, " data"}, dn_if.cmd_data, 8'(base + step * got));
                check({tag, " last"}, dn_if.cmd_last, (got == n - 1));
                got++;
            end
            tick();
            cyc++;
        end
        check({tag, " count"}, got, n);
        check({tag, " valid drops"}, dn_if.cmd_valid, 1'b0);
        dn_if.cmd_ready = 1'b1;
    endtask

    task automatic watch_quiet(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            if (dn_if.cmd_valid) seen++;
            tick();
        end
        check({tag, " no cmd_valid"}, seen, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        is_arp = 1'b0; udp_payload_valid = 1'b0; udp_payload_last = 1'b0; frame_done = 1'b0;
        udp_payload = '0;
        set_hdr('0, '0, '0, '0, '0);
        dn_if.cmd_ready = 1'b0;
        dn_if.arp_ack   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst cmd_valid", dn_if.cmd_valid, 1'b0);
        check("rst cmd_last", dn_if.cmd_last, 1'b0);
        check("rst cmd_data", dn_if.cmd_data, 8'h00);
        check("rst arp_req", dn_if.arp_req, 1'b0);
        check("rst arp_mac", dn_if.arp_mac, 48'h0);
        check("rst reply", {reply_ip, reply_port}, 48'h0);
        check("rst stats", {stat_rx_ok, stat_rx_drop}, 32'h0);

        // Test 1: accepted frame, full throughput
        set_hdr(48'h0A0B_0C0D_0E0F, 32'hC0A8_0105, 16'h1234, LOCAL_PORT, LOCAL_IP);
        dn_if.cmd_ready = 1'b1;
        send_frame(3, 8'h11, 8'h11);
        check("t1 valid one cycle after commit", dn_if.cmd_valid, 1'b0);
        tick();
        check("t1 valid two cycles after commit", dn_if.cmd_valid, 1'b1);
        receive(3, 8'h11, 8'h11, 1'b0, "t1");
        check("t1 stat_rx_ok", stat_rx_ok, exp_stat(1));
        check("t1 reply_port", reply_port, 16'h1234);
        check("t1 reply_mac", reply_mac, 48'h0A0B_0C0D_0E0F);
        check("t1 reply_ip", reply_ip, 32'hC0A8_0105);

        // Test 2: wrong port, then wrong IP
        set_hdr(48'h1111_1111_1111, 32'h0A00_0001, 16'h9999, LOCAL_PORT + 16'd1, LOCAL_IP);
        send_frame(3, 8'h11, 8'h11);
        watch_quiet(6, "t2 port");
        check("t2 stat_rx_drop", stat_rx_drop, exp_stat(1));
        check("t2 reply_port", reply_port, 16'h1234);
        check("t2 reply_mac", reply_mac, 48'h0A0B_0C0D_0E0F);
        set_hdr(48'h2222_2222_2222, 32'h0A00_0002, 16'h8888, LOCAL_PORT, LOCAL_IP + 32'd1);
        send_frame(2, 8'h55, 8'h01);
        watch_quiet(6, "t2 ip");
        check("t2 ip stat_rx_drop", stat_rx_drop, exp_stat(2));

        // Test 3: overflow, then normal and exactly-full frames
        set_hdr(48'h3333_3333_3333, 32'h0A00_0003, 16'h2222, LOCAL_PORT, LOCAL_IP);
        send_frame(65, 8'h00, 8'h01);
        watch_quiet(6, "t3 overflow");
        check("t3 stat_rx_drop", stat_rx_drop, exp_stat(3));
        check("t3 reply_port", reply_port, 16'h1234);
        set_hdr(48'h4444_4444_4444, 32'h0A00_0004, 16'h4444, LOCAL_PORT, LOCAL_IP);
        send_frame(4, 8'hA0, 8'h01);
        tick();
        receive(4, 8'hA0, 8'h01, 1'b0, "t3 four");
        check("t3 stat_rx_ok", stat_rx_ok, exp_stat(2));
        check("t3 reply_port", reply_port, 16'h4444);
        send_frame(64, 8'h40, 8'h01);
        tick();
        receive(64, 8'h40, 8'h01, 1'b0, "t3 full");
        check("t3 full stat_rx_ok", stat_rx_ok, exp_stat(3));

        // Test 4: stalling consumer with a second frame during the drain
        set_hdr(48'h5555_5555_5555, 32'h0A00_0005, 16'h5555, LOCAL_PORT, LOCAL_IP);
        send_frame(8, 8'h80, 8'h03);
        tick();
        fork
            receive(8, 8'h80, 8'h03, 1'b1, "t4");
            begin
                repeat (3) tick();
                set_hdr(48'h7777_7777_7777, 32'h0A00_0007, 16'h7777, LOCAL_PORT, LOCAL_IP);
                send_frame(2, 8'hEE, 8'h01);
            end
        join
        watch_quiet(6, "t4 after drain");
        check("t4 stat_rx_ok", stat_rx_ok, exp_stat(4));
        check("t4 stat_rx_drop", stat_rx_drop, exp_stat(4));
        check("t4 reply_port", reply_port, 16'h5555);

        // Test 5: ARP request/ack
        arp_frame(48'h0200_0000_0001, 1'b0);
        check("t5 arp_req set", dn_if.arp_req, 1'b1);
        check("t5 arp_mac", dn_if.arp_mac, 48'h0200_0000_0001);
        arp_frame(48'h0200_0000_0002, 1'b0);
        check("t5 second arp keeps req", dn_if.arp_req, 1'b1);
        check("t5 second arp ignored", dn_if.arp_mac, 48'h0200_0000_0001);
        check("t5 arp no drop", stat_rx_drop, exp_stat(4));
        dn_if.arp_ack = 1'b1;
        tick();
        dn_if.arp_ack = 1'b0;
        check("t5 ack clears req", dn_if.arp_req, 1'b0);
        arp_frame(48'h0200_0000_0003, 1'b0);
        check("t5 third arp mac", dn_if.arp_mac, 48'h0200_0000_0003);
        arp_frame(48'h0200_0000_0004, 1'b1);
        check("t5 ack wins req", dn_if.arp_req, 1'b0);
        check("t5 ack wins mac", dn_if.arp_mac, 48'h0200_0000_0003);
        tick();
        check("t5 discarded stays clear", dn_if.arp_req, 1'b0);

        // Test 6: reset during drain
        arp_frame(48'h0200_0000_0005, 1'b0);
        set_hdr(48'h6666_6666_6666, 32'h0A00_0006, 16'h6666, LOCAL_PORT, LOCAL_IP);
        dn_if.cmd_ready = 1'b0;
        send_frame(3, 8'h31, 8'h01);
        repeat (2) tick();
        check("t6 stalled valid", {dn_if.cmd_valid, dn_if.cmd_data}, {1'b1, 8'h31});
        rst_n = 1'b0;
        tick();
        check("t6 rst cmd_valid", dn_if.cmd_valid, 1'b0);
        check("t6 rst cmd_data", dn_if.cmd_data, 8'h00);
        check("t6 rst arp_req", dn_if.arp_req, 1'b0);
        check("t6 rst stats", {stat_rx_ok, stat_rx_drop}, 32'h0);
        check("t6 rst reply", {reply_mac, reply_port}, 64'h0);
        rst_n = 1'b1;
        tick();
        dn_if.cmd_ready = 1'b1;
        set_hdr(48'h6767_6767_6767, 32'h0A00_0067, 16'h6767, LOCAL_PORT, LOCAL_IP);
        send_frame(2, 8'h5A, 8'h01);
        tick();
        receive(2, 8'h5A, 8'h01, 1'b0, "t6 recover");
        check("t6 recover stat_rx_ok", stat_rx_ok, exp_stat(1));
        check("t6 recover reply_port", reply_port, 16'h6767);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
